// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   * MIPS funct codes of the eight HI/LO instructions
//   * FSM state encoding
//   * decoded operation enum and a funct decoder
//   * DIV0_LO: bit used to fill LO on a divide by zero
package mdu_pkg;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  // LO becomes {WIDTH{DIV0_LO}} when the divisor is zero.
  localparam logic DIV0_LO = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_e;

  typedef enum logic [3:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } mdu_op_e;

  function automatic mdu_op_e decode_funct(input logic [5:0] funct);
    case (funct)
      F_MULT:  return OP_MULT;
      F_MULTU: return OP_MULTU;
      F_DIV:   return OP_DIV;
      F_DIVU:  return OP_DIVU;
      F_MFHI:  return OP_MFHI;
      F_MFLO:  return OP_MFLO;
      F_MTHI:  return OP_MTHI;
      F_MTLO:  return OP_MTLO;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- EX-stage <-> multiply/divide unit signal bundle.
//   master (pipeline): drives Start, Funct, SrcA, SrcB, Flush
//   slave  (MDU)     : drives Stall, Busy, Done, Result, Hi, Lo
interface muldiv_unit_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
);
  logic               Start;
  logic [FUNCT_W-1:0] Funct;
  logic [WIDTH-1:0]   SrcA;
  logic [WIDTH-1:0]   SrcB;
  logic               Flush;
  logic               Stall;
  logic               Busy;
  logic               Done;
  logic [WIDTH-1:0]   Result;
  logic [WIDTH-1:0]   Hi;
  logic [WIDTH-1:0]   Lo;

  modport master (
    output Start, Funct, SrcA, SrcB, Flush,
    input  Stall, Busy, Done, Result, Hi, Lo
  );

  modport slave (
    input  Start, Funct, SrcA, SrcB, Flush,
    output Stall, Busy, Done, Result, Hi, Lo
  );
endinterface

// File: rtl/mdu_divider.sv
// mdu_divider -- restoring radix-2 divide datapath plus the WIDTH-step
// counter that paces both the multiply and divide sequences.
//   clk, rst_n          : clock / async active-low reset
//   load                : capture dividend/divisor, clear counter
//   step                : perform one restoring step, advance counter
//   dividend, divisor   : unsigned magnitudes
//   quotient, remainder : results, valid after WIDTH steps
//   last_step           : the step happening this cycle is the final one
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last_step
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH:0]   trial;

  // Partial remainder with the next dividend bit shifted in, minus divisor.
  // Bit WIDTH set means the subtraction borrowed, so the step restores.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    count_d = count_q;
    if (load) begin
      rem_d   = '0;
      quo_d   = dividend;
      dvs_d   = divisor;
      count_d = '0;
    end else if (step) begin
      count_d = count_q + 1'b1;
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last_step = (count_q == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- multi-cycle MIPS multiply/divide unit with HI/LO registers.
//   clk, rst_n : clock / async active-low reset
//   bus        : muldiv_unit_if slave port
//                in : Start, Funct, SrcA, SrcB, Flush
//                out: Stall, Busy, Done, Result, Hi, Lo
// mult/multu/div/divu run on magnitudes for WIDTH steps, then one FIX cycle
// applies signs and writes HI/LO. mthi/mtlo write in one edge; mfhi/mflo
// read combinationally.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  mdu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d, div0_q, div0_d;
  logic is_div_q, is_div_d, done_q, done_d;

  logic [FUNCT_W-1:0] funct;
  mdu_op_e            op;
  logic               is_mul, is_div, signed_op, neg_a_in, neg_b_in, accept, step;
  logic               busy, last_step;
  logic [WIDTH-1:0]   abs_a, abs_b, quotient, remainder;
  logic [WIDTH-1:0]   quo_signed, rem_signed, dividend_orig;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_signed;

  assign funct     = bus.Funct;
  assign op        = decode_funct(6'(funct));
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign neg_a_in  = signed_op & bus.SrcA[WIDTH-1];
  assign neg_b_in  = signed_op & bus.SrcB[WIDTH-1];
  assign abs_a     = neg_a_in ? -bus.SrcA : bus.SrcA;
  assign abs_b     = neg_b_in ? -bus.SrcB : bus.SrcB;
  assign busy      = (state_q != S_IDLE);
  assign accept    = !busy && bus.Start && !bus.Flush && (is_mul || is_div);
  // The divider's counter paces the multiply too, so it steps in both states.
  assign step      = ((state_q == S_MUL) || (state_q == S_DIV)) && !bus.Flush;

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quotient),
    .remainder (remainder),
    .last_step (last_step)
  );

  // Shift-add: multiplier sits in prod_q low half, consumed LSB first;
  // the carry out of the add becomes the new top bit on the right shift.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));

  // mcand_q doubles as the stored dividend magnitude during a divide.
  assign prod_signed   = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
  assign quo_signed    = (neg_a_q ^ neg_b_q) ? -quotient : quotient;
  assign rem_signed    = neg_a_q ? -remainder : remainder;
  assign dividend_orig = neg_a_q ? -mcand_q : mcand_q;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Flush) begin
          if (is_mul || is_div) begin
            state_d  = is_mul ? S_MUL : S_DIV;
            mcand_d  = abs_a;
            prod_d   = {{WIDTH{1'b0}}, abs_b};
            neg_a_d  = neg_a_in;
            neg_b_d  = neg_b_in;
            div0_d   = (bus.SrcB == '0);
            is_div_d = is_div;
          end else if (op == OP_MTHI) begin
            hi_d = bus.SrcA;
          end else if (op == OP_MTLO) begin
            lo_d = bus.SrcA;
          end
        end
      end
      S_MUL: begin
        if (bus.Flush) begin
          state_d = S_IDLE;
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          if (last_step) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (bus.Flush)      state_d = S_IDLE;
        else if (last_step) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.Flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_signed[2*WIDTH-1:WIDTH];
            lo_d = prod_signed[WIDTH-1:0];
          end else if (div0_q) begin
            // Restoring division by zero is meaningless after sign fix-up.
            lo_d = {WIDTH{DIV0_LO}};
            hi_d = dividend_orig;
          end else begin
            lo_d = quo_signed;
            hi_d = rem_signed;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    bus.Result = '0;
    if (bus.Start && (op == OP_MFHI)) bus.Result = hi_q;
    if (bus.Start && (op == OP_MFLO)) bus.Result = lo_q;
  end

  assign bus.Busy  = busy;
  assign bus.Stall = busy && bus.Start && (op != OP_NONE);
  assign bus.Done  = done_q;
  assign bus.Hi    = hi_q;
  assign bus.Lo    = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit (WIDTH=32).
// Expected HI/LO come from 64-bit integer arithmetic in a reference task.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_unit_if #(.WIDTH(W), .FUNCT_W(6)) bus ();
  muldiv_unit #(.WIDTH(W), .FUNCT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: MIPS HI/LO semantics via 64-bit integer math.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = '0;
    lo = '0;
    p  = '0;
    if (f == F_MULT) begin
      p = sa * sb; hi = p[63:32]; lo = p[31:0];
    end else if (f == F_MULTU) begin
      p = ua * ub; hi = p[63:32]; lo = p[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF; hi = a;
    end else if (f == F_DIV) begin
      q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r);
    end else begin
      lo = 32'(ua / ub); hi = 32'(ua % ub);
    end
  endtask

  // Drives one mul/div and measures Busy length and the Done pulse.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int busy_n, output logic done_end, output logic done_next);
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct = f; bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.Funct = F_ADD;
    busy_n = 0;
    while (bus.Busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
    if (busy_n >= 100) busy_n = -1;
    done_end = bus.Done;
    @(negedge clk);
    done_next = bus.Done;
    $display("op f=%b a=%h b=%h -> hi=%h lo=%h busy=%0d", f, a, b, bus.Hi, bus.Lo, busy_n);
  endtask

  task automatic write_hilo(input logic [5:0] f, input logic [31:0] d);
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct = f; bus.SrcA = d;
    @(negedge clk);
    bus.Start = 1'b0; bus.Funct = F_ADD;
    $display("move f=%b data=%h -> hi=%h lo=%h", f, d, bus.Hi, bus.Lo);
  endtask

  task automatic test_reset;
    bus.Start = 1'b0; bus.Funct = F_ADD; bus.SrcA = '0; bus.SrcB = '0; bus.Flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.Start = 1'b1; bus.Funct = F_MFHI;
    #1;
    n_cmp++; if (bus.Busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    n_cmp++; if (bus.Done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    n_cmp++; if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.Stall); end
    n_cmp++; if (bus.Hi !== 32'd0)   begin n_err++; $display("FAIL reset_hi: got %h want 0", bus.Hi); end
    n_cmp++; if (bus.Lo !== 32'd0)   begin n_err++; $display("FAIL reset_lo: got %h want 0", bus.Lo); end
    n_cmp++; if (bus.Result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.Result); end
    bus.Start = 1'b0; bus.Funct = F_ADD;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_arith_vectors;
    logic [5:0]  vf [6];
    logic [31:0] va [6], vb [6], vh [6], vl [6];
    int busy_n;
    logic d0, d1;
    vf[0] = F_MULT;  va[0] = 32'hFFFF_FFFF; vb[0] = 32'h2; vh[0] = 32'hFFFF_FFFF; vl[0] = 32'hFFFF_FFFE;
    vf[1] = F_MULTU; va[1] = 32'hFFFF_FFFF; vb[1] = 32'h2; vh[1] = 32'h1;         vl[1] = 32'hFFFF_FFFE;
    vf[2] = F_DIV;   va[2] = 32'hFFFF_FFF9; vb[2] = 32'h2; vh[2] = 32'hFFFF_FFFF; vl[2] = 32'hFFFF_FFFD;
    vf[3] = F_DIVU;  va[3] = 32'h7;         vb[3] = 32'h2; vh[3] = 32'h1;         vl[3] = 32'h3;
    vf[4] = F_DIVU;  va[4] = 32'h5;         vb[4] = 32'h0; vh[4] = 32'h5;         vl[4] = 32'hFFFF_FFFF;
    vf[5] = F_DIV;   va[5] = 32'h8000_0000; vb[5] = 32'hFFFF_FFFF; vh[5] = 32'h0; vl[5] = 32'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      do_op(vf[i], va[i], vb[i], busy_n, d0, d1);
      n_cmp++; if (busy_n != W + 1) begin n_err++; $display("FAIL vec%0d_busy_cycles: got %0d want %0d", i, busy_n, W + 1); end
      n_cmp++; if (d0 !== 1'b1) begin n_err++; $display("FAIL vec%0d_done_pulse: got %b want 1", i, d0); end
      n_cmp++; if (d1 !== 1'b0) begin n_err++; $display("FAIL vec%0d_done_width: got %b want 0", i, d1); end
      n_cmp++; if (bus.Hi !== vh[i]) begin n_err++; $display("FAIL vec%0d_hi: got %h want %h", i, bus.Hi, vh[i]); end
      n_cmp++; if (bus.Lo !== vl[i]) begin n_err++; $display("FAIL vec%0d_lo: got %h want %h", i, bus.Lo, vl[i]); end
    end
    // mfhi/mflo read back combinationally without stalling
    bus.Start = 1'b1; bus.Funct = F_MFHI;
    #1;
    n_cmp++; if (bus.Result !== vh[5]) begin n_err++; $display("FAIL mfhi_result: got %h want %h", bus.Result, vh[5]); end
    bus.Funct = F_MFLO;
    #1;
    n_cmp++; if (bus.Result !== vl[5]) begin n_err++; $display("FAIL mflo_result: got %h want %h", bus.Result, vl[5]); end
    n_cmp++; if (bus.Stall !== 1'b0)   begin n_err++; $display("FAIL mflo_idle_stall: got %b want 0", bus.Stall); end
    bus.Start = 1'b0; bus.Funct = F_ADD;
  endtask

  task automatic test_random;
    logic [5:0]  fsel [4];
    logic [5:0]  f;
    logic [31:0] a, b, eh, el;
    int busy_n, k;
    logic d0, d1;
    fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV; fsel[3] = F_DIVU;
    for (int i = 0; i < 16; i++) begin
      f = fsel[$urandom_range(0, 3)];
      a = $urandom;
      k = $urandom_range(0, 7);
      if (k == 0)      b = 32'd0;
      else if (k == 1) b = 32'($urandom_range(1, 15));
      else if (k == 2) b = 32'hFFFF_FFFF;
      else             b = $urandom;
      if (k == 2 && i[0]) a = 32'h8000_0000;
      model(f, a, b, eh, el);
      do_op(f, a, b, busy_n, d0, d1);
      n_cmp++; if (busy_n != W + 1) begin n_err++; $display("FAIL rand%0d_busy_cycles: got %0d want %0d", i, busy_n, W + 1); end
      n_cmp++; if (bus.Hi !== eh) begin n_err++; $display("FAIL rand%0d_hi: f=%b a=%h b=%h got %h want %h", i, f, a, b, bus.Hi, eh); end
      n_cmp++; if (bus.Lo !== el) begin n_err++; $display("FAIL rand%0d_lo: f=%b a=%h b=%h got %h want %h", i, f, a, b, bus.Lo, el); end
    end
  endtask

  task automatic test_stall;
    logic [31:0] a, b, eh, el;
    int cyc;
    a = $urandom; b = $urandom;
    model(F_MULT, a, b, eh, el);
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct = F_MULT; bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.Funct = F_ADD;
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 5) begin bus.Start = 1'b1; bus.Funct = F_MFLO; end
      #1;
      if (cyc >= 5) begin
        n_cmp++; if (bus.Stall !== 1'b1) begin n_err++; $display("FAIL mflo_busy_stall cyc%0d: got %b want 1", cyc, bus.Stall); end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (cyc != W + 1)         begin n_err++; $display("FAIL stall_busy_cycles: got %0d want %0d", cyc, W + 1); end
    n_cmp++; if (bus.Done !== 1'b1)    begin n_err++; $display("FAIL stall_done: got %b want 1", bus.Done); end
    n_cmp++; if (bus.Stall !== 1'b0)   begin n_err++; $display("FAIL stall_release: got %b want 0", bus.Stall); end
    n_cmp++; if (bus.Result !== el)    begin n_err++; $display("FAIL mflo_done_result: got %h want %h", bus.Result, el); end
    $display("stall mult a=%h b=%h mflo=%h", a, b, bus.Result);
    bus.Start = 1'b0; bus.Funct = F_ADD;
    // mtlo presented while busy must stall and not be latched
    a = $urandom; b = $urandom;
    model(F_MULTU, a, b, eh, el);
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct = F_MULTU; bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.Funct = F_ADD;
    repeat (2) @(negedge clk);
    bus.Start = 1'b1; bus.Funct = F_MTLO; bus.SrcA = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (bus.Stall !== 1'b1) begin n_err++; $display("FAIL mtlo_busy_stall: got %b want 1", bus.Stall); end
    repeat (2) @(negedge clk);
    bus.Start = 1'b0; bus.Funct = F_ADD;
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    n_cmp++; if (bus.Lo !== el) begin n_err++; $display("FAIL mtlo_not_latched: got %h want %h", bus.Lo, el); end
    $display("stall multu a=%h b=%h lo=%h", a, b, bus.Lo);
  endtask

  task automatic test_flush;
    int cyc;
    logic done_seen;
    write_hilo(F_MTHI, 32'h1111_2222);
    write_hilo(F_MTLO, 32'h3333_4444);
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct = F_DIV; bus.SrcA = 32'd1000; bus.SrcB = 32'd7;
    @(negedge clk);
    bus.Start = 1'b0; bus.Funct = F_ADD;
    cyc = 1;
    while (cyc < 10) begin cyc++; @(negedge clk); end
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", bus.Busy); end
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_seen = 1'b1;
    end
    n_cmp++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL flush_no_done: got %b want 0", done_seen); end
    n_cmp++; if (bus.Hi !== 32'h1111_2222) begin n_err++; $display("FAIL flush_hi: got %h want 11112222", bus.Hi); end
    n_cmp++; if (bus.Lo !== 32'h3333_4444) begin n_err++; $display("FAIL flush_lo: got %h want 33334444", bus.Lo); end
    $display("flush div aborted hi=%h lo=%h", bus.Hi, bus.Lo);
    // Flush beats Start in IDLE
    bus.Start = 1'b1; bus.Funct = F_MULT; bus.SrcA = 32'd3; bus.Flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy: got %b want 0", bus.Busy); end
    bus.Funct = F_MTHI; bus.SrcA = 32'hFFFF_0000;
    @(negedge clk);
    bus.Start = 1'b0; bus.Funct = F_ADD; bus.Flush = 1'b0;
    n_cmp++; if (bus.Hi !== 32'h1111_2222) begin n_err++; $display("FAIL flush_mthi_dropped: got %h want 11112222", bus.Hi); end
    // Non-MDU funct with Start is ignored
    bus.Start = 1'b1; bus.Funct = F_ADD; bus.SrcA = 32'h5555_5555;
    #1;
    n_cmp++; if (bus.Stall !== 1'b0)   begin n_err++; $display("FAIL other_funct_stall: got %b want 0", bus.Stall); end
    n_cmp++; if (bus.Result !== 32'd0) begin n_err++; $display("FAIL other_funct_result: got %h want 0", bus.Result); end
    @(negedge clk);
    bus.Start = 1'b0;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL other_funct_busy: got %b want 0", bus.Busy); end
    $display("flush-in-idle and foreign funct handled hi=%h", bus.Hi);
  endtask

  task automatic test_async_reset;
    int cyc;
    write_hilo(F_MTHI, 32'hA5A5_A5A5);
    write_hilo(F_MTLO, 32'h5A5A_5A5A);
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct = F_MULT; bus.SrcA = 32'd9; bus.SrcB = 32'd9;
    @(negedge clk);
    bus.Start = 1'b0; bus.Funct = F_ADD;
    cyc = 1;
    while (cyc < 7) begin cyc++; @(negedge clk); end
    rst_n = 1'b0;
    bus.Start = 1'b1; bus.Funct = F_MULT;
    #1;
    n_cmp++; if (bus.Busy !== 1'b0)  begin n_err++; $display("FAIL areset_busy: got %b want 0", bus.Busy); end
    n_cmp++; if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL areset_stall: got %b want 0", bus.Stall); end
    n_cmp++; if (bus.Hi !== 32'd0)   begin n_err++; $display("FAIL areset_hi: got %h want 0", bus.Hi); end
    n_cmp++; if (bus.Lo !== 32'd0)   begin n_err++; $display("FAIL areset_lo: got %h want 0", bus.Lo); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.Start = 1'b0; bus.Funct = F_ADD;
    @(negedge clk);
    n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL areset_done: got %b want 0", bus.Done); end
    write_hilo(F_MTHI, 32'h1234_5678);
    n_cmp++; if (bus.Hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_after_reset: got %h want 12345678", bus.Hi); end
    n_cmp++; if (bus.Lo !== 32'd0)         begin n_err++; $display("FAIL lo_after_reset: got %h want 0", bus.Lo); end
  endtask

  initial begin
    test_reset();
    test_arith_vectors();
    test_random();
    test_stall();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
